icache_dm_refill: RTL

- Parametrised, direct-mapped instruction cache between the fetch stage and the memory bus.
- Supersedes the fixed 16-byte, always-ready instruction store with a tagged, multi-line array and a burst refill engine.
- Hits return the instruction combinationally in the same cycle.
- Misses stall fetch (icache_r low) while a refill state machine fetches the whole line from memory.
- Includes a single-cycle flush and saturating hit/miss counters.

---
 rtl/icache_dm_refill_if.sv | 26 ++
 rtl/icache_dm_refill.sv | 135 +++++++++++++
 2 files changed

// File: rtl/icache_dm_refill_if.sv
// Fetch-side and memory-side signal bundle for the direct-mapped instruction cache.
// The master modport is the cache; the slave modport is the fetch stage plus memory bus.
interface icache_dm_refill_if #(
    parameter int ADDR_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] PC;
    logic                  fetch_valid;
    logic                  flush;
    logic                  icache_r;
    logic [31:0]           instruction;
    logic                  mem_req;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_gnt;
    logic                  mem_rvalid;
    logic [31:0]           mem_rdata;

    modport master (
        input  PC, fetch_valid, flush, mem_gnt, mem_rvalid, mem_rdata,
        output icache_r, instruction, mem_req, mem_addr
    );

    modport slave (
        output PC, fetch_valid, flush, mem_gnt, mem_rvalid, mem_rdata,
        input  icache_r, instruction, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_dm_refill.sv
// Direct-mapped instruction cache with combinational hits, a burst line-refill FSM,
// single-cycle flush and saturating hit/miss counters.
module icache_dm_refill #(
    parameter int ADDR_WIDTH = 64,
    parameter int NUM_LINES  = 16,
    parameter int LINE_WORDS = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 CLK,
    input  logic                 reset,
    icache_dm_refill_if.master   bus,
    output logic [CNT_WIDTH-1:0] hit_count,
    output logic [CNT_WIDTH-1:0] miss_count
);
    localparam int OFF  = $clog2(LINE_WORDS * 4);
    localparam int IDX  = $clog2(NUM_LINES);
    localparam int WB   = $clog2(LINE_WORDS);
    localparam int TAGW = ADDR_WIDTH - OFF - IDX;

    typedef enum logic [1:0] {IDLE, REQ, FILL} state_t;

    state_t state, state_next;

    logic [31:0]           data_mem [NUM_LINES*LINE_WORDS];
    logic [TAGW-1:0]       tag_mem  [NUM_LINES];
    logic [NUM_LINES-1:0]  valid;
    logic [ADDR_WIDTH-1:0] line_addr;
    logic [IDX-1:0]        lidx;
    logic [WB-1:0]         beat;
    logic                  poisoned;

    logic [IDX-1:0]  pc_index;
    logic [WB-1:0]   pc_word;
    logic [TAGW-1:0] pc_tag;
    logic [1:0]      pc_unused;
    logic            hit;
    logic            start_miss;
    logic            beat_accept;
    logic            last_beat;

    assign pc_index  = bus.PC[OFF+IDX-1:OFF];
    assign pc_word   = bus.PC[OFF-1:2];
    assign pc_tag    = bus.PC[ADDR_WIDTH-1:OFF+IDX];
    assign pc_unused = bus.PC[1:0];

    assign hit         = bus.fetch_valid && (state == IDLE) && valid[pc_index]
                         && (tag_mem[pc_index] == pc_tag);
    assign start_miss  = (state == IDLE) && bus.fetch_valid && !hit && !bus.flush;
    assign beat_accept = (state == FILL) && bus.mem_rvalid;
    assign last_beat   = beat_accept && (beat == WB'(LINE_WORDS - 1));

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_miss)  state_next = REQ;
            REQ:     if (bus.mem_gnt) state_next = FILL;
            FILL:    if (last_beat)   state_next = IDLE;
            default:                  state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.mem_req     = (state == REQ);
        bus.mem_addr    = line_addr;
        bus.icache_r    = hit;
        bus.instruction = 32'd0;
        if (hit) begin
            bus.instruction = data_mem[{pc_index, pc_word}];
        end
    end

    // A flush that lands mid-burst poisons the line so it is written but never marked valid.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            line_addr <= '0;
            lidx      <= '0;
            beat      <= '0;
            poisoned  <= 1'b0;
            valid     <= '0;
        end else begin
            if (start_miss) begin
                line_addr <= {bus.PC[ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                lidx      <= pc_index;
                poisoned  <= 1'b0;
            end else if (last_beat) begin
                poisoned  <= 1'b0;
            end else if (bus.flush && (state != IDLE)) begin
                poisoned  <= 1'b1;
            end

            if ((state == REQ) && bus.mem_gnt) begin
                beat <= '0;
            end else if (beat_accept) begin
                beat <= beat + 1'b1;
            end

            if (bus.flush) begin
                valid <= '0;
            end else if (last_beat && !poisoned) begin
                valid[lidx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (beat_accept) begin
            data_mem[{lidx, beat}] <= bus.mem_rdata;
        end
        if (last_beat) begin
            tag_mem[lidx] <= line_addr[ADDR_WIDTH-1:OFF+IDX];
        end
    end

    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit && (hit_count != '1)) begin
                hit_count <= hit_count + 1'b1;
            end
            if (start_miss && (miss_count != '1)) begin
                miss_count <= miss_count + 1'b1;
            end
        end
    end
endmodule
